// File: rtl/bsg_wait_after_reset_seq.sv
// Staged reset-release sequencer: after reset, releases els_p ready enables one at a time.
// Optional macro BSG_WAIT_AFTER_RESET_SEQ_ACK_EN gates each later stage on the previous stage's ack_i bit.
module bsg_wait_after_reset_seq #(
  parameter  int els_p            = 4,
  parameter  int wait_cycles_p    = 31,
  parameter  int stagger_cycles_p = 8,
  localparam int stage_width_lp   = ($clog2(els_p+1) < 1) ? 1 : $clog2(els_p+1),
  localparam int max_cycles_lp    = (wait_cycles_p > stagger_cycles_p) ? wait_cycles_p : stagger_cycles_p,
  localparam int ctr_width_lp     = ($clog2(max_cycles_lp+1) < 1) ? 1 : $clog2(max_cycles_lp+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      restart_i,
  input  logic [els_p-1:0]          ack_i,
  output logic [els_p-1:0]          ready_r_o,
  output logic                      all_ready_r_o,
  output logic [stage_width_lp-1:0] stage_r_o
);

  typedef enum logic [1:0] {
    eWait    = 2'd0,
    eStagger = 2'd1,
    eAck     = 2'd2,
    eDone    = 2'd3
  } state_e;

  localparam logic [ctr_width_lp-1:0]   wait_load_lp    = ctr_width_lp'(wait_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0]   stagger_load_lp = ctr_width_lp'(stagger_cycles_p - 1);
  localparam logic [stage_width_lp-1:0] last_idx_lp     = stage_width_lp'(els_p);

  state_e                    state_r, state_n;
  logic [ctr_width_lp-1:0]   ctr_r, ctr_n;
  logic [stage_width_lp-1:0] idx_r, idx_n;
  logic [els_p-1:0]          ready_r, ready_n;
  logic                      all_r, all_n;
  logic                      ack_sel;

`ifdef BSG_WAIT_AFTER_RESET_SEQ_ACK_EN
  // ack_i[idx_r-1] belongs to the most recently released stage
  always_comb begin
    ack_sel = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (stage_width_lp'(i+1) == idx_r) ack_sel = ack_i[i];
    end
  end
`else
  logic unused_ack;
  assign unused_ack = ^ack_i;
  assign ack_sel    = 1'b0;
`endif

  always_comb begin
    state_n = state_r;
    ctr_n   = ctr_r;
    idx_n   = idx_r;
    ready_n = ready_r;

    unique case (state_r)
      eWait: begin
        if (ctr_r == '0) begin
          ready_n[0] = 1'b1;
          idx_n      = stage_width_lp'(1);
          if (els_p == 1) begin
            state_n = eDone;
          end else begin
`ifdef BSG_WAIT_AFTER_RESET_SEQ_ACK_EN
            state_n = eAck;
`else
            state_n = eStagger;
            ctr_n   = stagger_load_lp;
`endif
          end
        end else begin
          ctr_n = ctr_r - ctr_width_lp'(1);
        end
      end

      eStagger: begin
        if (ctr_r == '0) begin
          for (int i = 0; i < els_p; i++) begin
            if (stage_width_lp'(i) == idx_r) ready_n[i] = 1'b1;
          end
          idx_n = idx_r + stage_width_lp'(1);
          if (idx_n == last_idx_lp) begin
            state_n = eDone;
          end else begin
`ifdef BSG_WAIT_AFTER_RESET_SEQ_ACK_EN
            state_n = eAck;
`else
            ctr_n   = stagger_load_lp;
`endif
          end
        end else begin
          ctr_n = ctr_r - ctr_width_lp'(1);
        end
      end

      eAck: begin
        // no timeout: the handoff stalls until the previous stage acknowledges
        if (ack_sel) begin
          ctr_n   = stagger_load_lp;
          state_n = eStagger;
        end
      end

      eDone: begin
      end

      default: begin
        state_n = eWait;
        ctr_n   = wait_load_lp;
      end
    endcase

    all_n = ready_n[els_p-1];
  end

  // restart is a soft alias of reset, so asserting both has no extra effect
  always_ff @(posedge clk_i) begin
    if (reset_i | restart_i) begin
      state_r <= eWait;
      ctr_r   <= wait_load_lp;
      idx_r   <= '0;
      ready_r <= '0;
      all_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      ctr_r   <= ctr_n;
      idx_r   <= idx_n;
      ready_r <= ready_n;
      all_r   <= all_n;
    end
  end

  assign ready_r_o     = ready_r;
  assign all_ready_r_o = all_r;
  assign stage_r_o     = idx_r;

endmodule

// File: tb/tb_bsg_wait_after_reset_seq.sv
// Directed bench for bsg_wait_after_reset_seq: default instance plus an els_p=1, wait_cycles_p=1 corner instance.
module tb_bsg_wait_after_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic [3:0] ack;
  logic [3:0] ready;
  logic       allReady;
  logic [2:0] stage;
  logic [0:0] ready1;
  logic       allReady1;
  logic [0:0] stage1;

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;

`ifdef BSG_WAIT_AFTER_RESET_SEQ_ACK_EN
  localparam int E1 = 40, E2 = 49, E3 = 58;
`else
  localparam int E1 = 39, E2 = 47, E3 = 55;
`endif

  typedef struct {
    int         edgeN;
    logic [3:0] expReady;
    logic       expAll;
    logic [2:0] expStage;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  bsg_wait_after_reset_seq dut (
    .clk_i(clk), .reset_i(reset), .restart_i(restart), .ack_i(ack),
    .ready_r_o(ready), .all_ready_r_o(allReady), .stage_r_o(stage)
  );

  bsg_wait_after_reset_seq #(.els_p(1), .wait_cycles_p(1), .stagger_cycles_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .restart_i(restart), .ack_i(ack[0:0]),
    .ready_r_o(ready1), .all_ready_r_o(allReady1), .stage_r_o(stage1)
  );

  task automatic applyStimulus(input logic r, input logic rs, input logic [3:0] a);
    reset   = r;
    restart = rs;
    ack     = a;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  task automatic runTo(input int e);
    while (edgeNum < e) stepEdge();
  endtask

  // drive r/rs over one edge, which becomes edge 0, then release
  task automatic releaseFrom(input logic r, input logic rs);
    applyStimulus(r, rs, ack);
    stepEdge();
    edgeNum = 0;
    applyStimulus(1'b0, 1'b0, ack);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] er, input logic ea, input logic [2:0] es);
    checks++;
    if (ready !== er || allReady !== ea || stage !== es) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: got ready=%b all=%b stage=%0d, want ready=%b all=%b stage=%0d",
               name, edgeNum, ready, allReady, stage, er, ea, es);
    end
  endtask

  task automatic checkSmall(input string name, input logic er, input logic ea, input logic es);
    checks++;
    if (ready1 !== er || allReady1 !== ea || stage1 !== es) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: got ready=%b all=%b stage=%0d, want ready=%b all=%b stage=%0d",
               name, edgeNum, ready1, allReady1, stage1, er, ea, es);
    end
  endtask

  task automatic checkThermo(input int cyc);
    logic [3:0] nextUp;
    nextUp = ready + 4'd1;
    checks++;
    if ((nextUp & ready) != 4'd0 || stage != 3'($countones(ready)) || allReady !== ready[3]) begin
      errors++;
      $display("[TB] FAIL thermo cycle %0d: got ready=%b all=%b stage=%0d, want thermometer with stage=popcount",
               cyc, ready, allReady, stage);
    end
  endtask

  initial begin
    vecs[0] = '{1,    4'b0000, 1'b0, 3'd0};
    vecs[1] = '{30,   4'b0000, 1'b0, 3'd0};
    vecs[2] = '{31,   4'b0001, 1'b0, 3'd1};
    vecs[3] = '{E1-1, 4'b0001, 1'b0, 3'd1};
    vecs[4] = '{E1,   4'b0011, 1'b0, 3'd2};
    vecs[5] = '{E2-1, 4'b0011, 1'b0, 3'd2};
    vecs[6] = '{E2,   4'b0111, 1'b0, 3'd3};
    vecs[7] = '{E3-1, 4'b0111, 1'b0, 3'd3};
    vecs[8] = '{E3,   4'b1111, 1'b1, 3'd4};
    vecs[9] = '{E3+5, 4'b1111, 1'b1, 3'd4};

    applyStimulus(1'b1, 1'b0, 4'b1111);
    repeat (2) stepEdge();
    releaseFrom(1'b1, 1'b0);
    checkOutput("reset_state", 4'b0000, 1'b0, 3'd0);
    checkSmall("els1_reset_state", 1'b0, 1'b0, 1'b0);
    runTo(1);
    checkSmall("els1_edge1", 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      runTo(vecs[i].edgeN);
      checkOutput($sformatf("seq_vec%0d", i), vecs[i].expReady, vecs[i].expAll, vecs[i].expStage);
    end

    // reset mid-sequence
    releaseFrom(1'b1, 1'b0);
    runTo(40);
    checkOutput("mid_before", 4'b0011, 1'b0, 3'd2);
    releaseFrom(1'b1, 1'b0);
    checkOutput("mid_reset_clear", 4'b0000, 1'b0, 3'd0);
    runTo(30);
    checkOutput("mid_edge30", 4'b0000, 1'b0, 3'd0);
    runTo(31);
    checkOutput("mid_edge31", 4'b0001, 1'b0, 3'd1);
    runTo(70);
    checkOutput("mid_done", 4'b1111, 1'b1, 3'd4);

    // restart after done
    releaseFrom(1'b0, 1'b1);
    checkOutput("restart_clear", 4'b0000, 1'b0, 3'd0);
    runTo(30);
    checkOutput("restart_edge30", 4'b0000, 1'b0, 3'd0);
    runTo(31);
    checkOutput("restart_edge31", 4'b0001, 1'b0, 3'd1);
    runTo(E3-1);
    checkOutput("restart_pre_all", 4'b0111, 1'b0, 3'd3);
    runTo(E3);
    checkOutput("restart_all", 4'b1111, 1'b1, 3'd4);

    // reset and restart together
    releaseFrom(1'b1, 1'b1);
    checkOutput("both_clear", 4'b0000, 1'b0, 3'd0);
    runTo(31);
    checkOutput("both_edge31", 4'b0001, 1'b0, 3'd1);

    // restart mid-sequence
    runTo(35);
    releaseFrom(1'b0, 1'b1);
    checkOutput("midrestart_clear", 4'b0000, 1'b0, 3'd0);
    runTo(31);
    checkOutput("midrestart_edge31", 4'b0001, 1'b0, 3'd1);

    // restart held high for 10 cycles
    applyStimulus(1'b0, 1'b1, ack);
    for (int i = 0; i < 10; i++) begin
      stepEdge();
      checkOutput("restart_held", 4'b0000, 1'b0, 3'd0);
      checkSmall("els1_restart_held", 1'b0, 1'b0, 1'b0);
    end
    edgeNum = 0;
    applyStimulus(1'b0, 1'b0, ack);
    runTo(1);
    checkSmall("els1_after_held", 1'b1, 1'b1, 1'b1);
    checkOutput("held_edge1", 4'b0000, 1'b0, 3'd0);
    runTo(31);
    checkOutput("held_edge31", 4'b0001, 1'b0, 3'd1);

`ifdef BSG_WAIT_AFTER_RESET_SEQ_ACK_EN
    // ack withheld until edge 51
    applyStimulus(1'b0, 1'b1, 4'b0000);
    stepEdge();
    edgeNum = 0;
    applyStimulus(1'b0, 1'b0, 4'b0000);
    runTo(50);
    checkOutput("ack_stall50", 4'b0001, 1'b0, 3'd1);
    ack = 4'b1111;
    runTo(58);
    checkOutput("ack_edge58", 4'b0001, 1'b0, 3'd1);
    runTo(59);
    checkOutput("ack_edge59", 4'b0011, 1'b0, 3'd2);
`endif

    // random restart/ack stress: ready must stay a thermometer
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'b0, ($urandom_range(0, 40) == 0), 4'($urandom));
      stepEdge();
      checkThermo(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_wait_after_reset_seq.md
# bsg_wait_after_reset_seq

Parametrised successor to the single-output wait-after-reset counter. After `reset_i` deasserts, it releases `els_p` downstream domains one at a time. Stage 0 releases after `wait_cycles_p` cycles, and each later stage releases `stagger_cycles_p` cycles after the previous one. It sits at the chip/tile reset root and drives staged `ready` enables into memories, PLL-dependent logic and I/O. It also supports a soft restart and, optionally, an acknowledged handoff between stages.

## Interface
Parameters:
- `els_p`, default 4: number of staged ready outputs; legal range ≥1.
- `wait_cycles_p`, default 31: cycles from reset release to `ready_r_o[0]`; legal range ≥1.
- `stagger_cycles_p`, default 8: cycles between consecutive stage releases; legal range ≥1.

Ports:
- `clk_i` in, 1: single clock. One clock; reset is synchronous and active-high.
- `reset_i` in, 1: synchronous, active-high reset; highest priority.
- `restart_i` in, 1: synchronous soft restart, active-high, level-sampled.
- `ack_i` in, `els_p`: per-stage acknowledge. Used only when `BSG_WAIT_AFTER_RESET_SEQ_ACK_EN` is defined; ignored otherwise.
- `ready_r_o` out, `els_p`: registered thermometer of released stages.
- `all_ready_r_o` out, 1: registered; equals `ready_r_o[els_p-1]`.
- `stage_r_o` out, `$clog2(els_p+1)`, min 1: number of stages released so far, in the range 0..`els_p`.

## Operation
- Internal counter width is `$clog2(max(wait_cycles_p, stagger_cycles_p)+1)`. The counter counts down and never wraps below 0; it is reloaded on each state entry.
- Stage index `idx_r` has width `$clog2(els_p+1)` and drives `stage_r_o` directly.
- FSM states and transitions:
  - `eWait`: counter loaded with `wait_cycles_p-1`. Decrements each cycle. When it is 0, set `ready_r_o[0]`, `idx_r`=1, and go to `eStagger`, or to `eDone` if `els_p==1`. In ACK mode go to `eAck` instead of `eStagger`.
  - `eStagger`: counter loaded with `stagger_cycles_p-1`. When it is 0, set `ready_r_o[idx_r]` and increment `idx_r`. If `idx_r` reaches `els_p`, go to `eDone`; otherwise reload and stay, or go to `eAck` in ACK mode.
  - `eAck` (ACK mode only): wait until `ack_i[idx_r-1]` is sampled high, then load the counter and go to `eStagger`. There is no timeout.
  - `eDone`: terminal. Outputs hold.
- Priority: `reset_i` > `restart_i` > normal operation.
- `reset_i` high on an edge: `ready_r_o`=0, `all_ready_r_o`=0, `stage_r_o`=0, state=`eWait`, counter reloaded.
- `restart_i` high with `reset_i` low: identical effect to reset. Usable in any state, including `eDone` and mid-sequence.
- Asserting `reset_i` and `restart_i` together behaves as a reset; there is no double effect.
- `ready_r_o` bits are monotonic between resets. Bit i is never set before bit i-1, and none are ever cleared except by reset or restart.
- Holding `restart_i` high keeps the block in `eWait` with all outputs 0. Counting begins on the first edge it is sampled low.

## Timing
- Edge 0 is the last rising edge with `reset_i` (or `restart_i`) sampled high.
- Without ACK mode, `ready_r_o[i]` rises on edge `wait_cycles_p + i*stagger_cycles_p` and is visible immediately after that edge.
- With defaults, stage 0 rises at edge 31, stage 1 at 39, stage 2 at 47, and stage 3 plus `all_ready_r_o` at 55.
- `all_ready_r_o` rises on the same edge as `ready_r_o[els_p-1]`.
- `stage_r_o` increments on the same edge as the corresponding ready bit.
- With ACK mode: if `ready_r_o[i]` rises on edge t, `ack_i[i]` is first sampled on edge t+1. If it is first seen high on edge a ≥ t+1, then `ready_r_o[i+1]` rises on edge a+`stagger_cycles_p`. The minimum per-stage gap is therefore `stagger_cycles_p+1`.
- All outputs are registers; no output depends combinationally on any input.

## Configuration
- Macro: `BSG_WAIT_AFTER_RESET_SEQ_ACK_EN`.
- Defined: the `eAck` state is built, and each stage after 0 waits for the previous stage's `ack_i` bit before its stagger count starts.
- Undefined: there is no `eAck` state, `ack_i` is unused, and release timing is purely counter-based per the formulas above.

## Test plan
- Defaults, no ACK: hold `reset_i` high 3 cycles, then low → `ready_r_o` is 0001 at edge 31, 0011 at 39, 0111 at 47, 1111 at 55. `all_ready_r_o`=1 at 55 and `stage_r_o`=4.
- Reset mid-sequence: assert `reset_i` at edge 40 → all outputs 0 on the next edge. Release at edge 41 → `ready_r_o[0]` at 41+31=72.
- Restart after done: pulse `restart_i` at edge 100 → outputs 0 at edge 100. `ready_r_o[0]` at 131, `all_ready_r_o` at 155. `reset_i`+`restart_i` together at an edge behave identically to a reset.
- ACK mode, defaults: `ack_i`=0 until first sampled high at edge 51 → `ready_r_o[1]` stays 0 through edge 58 and rises at 59. With `ack_i` tied high, the stages rise at 31, 40, 49, 58.
- Corner: `els_p`=1, `wait_cycles_p`=1 → `ready_r_o`=1 and `all_ready_r_o`=1 at edge 1. `restart_i` held high 10 cycles → outputs stay 0, and ready rises 1 edge after release.
- Monotonicity check across random `restart_i`/`ack_i` stimulus: assert `ready_r_o` is always a thermometer code and `stage_r_o` equals its popcount.
